// File: rtl/cordic_sched_pkg.sv
// Shared types and helpers for the CORDIC request scheduler.
// Holds the FSM state encoding and id/counter width sizing.
package cordic_sched_pkg;

  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ARB,
    START,
    WAIT,
    RESP
  } state_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_scheduler_if.sv
// Requester/response bundle for the CORDIC scheduler.
// slave = scheduler side, master = requester/consumer side.
interface cordic_scheduler_if
  import cordic_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = DW_DEF
) ();

  localparam int IW = id_w(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_theta;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IW-1:0]       rsp_id;
  logic [DW-1:0]       rsp_cos;
  logic [DW-1:0]       rsp_sin;
  logic                rsp_err;

  modport slave (
    input  req_valid, req_theta, rsp_ready,
    output req_ready, rsp_valid, rsp_id,
    output rsp_cos, rsp_sin, rsp_err
  );

  modport master (
    output req_valid, req_theta, rsp_ready,
    input  req_ready, rsp_valid, rsp_id,
    input  rsp_cos, rsp_sin, rsp_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin search starting one past last_grant.
// Produces a one-hot grant and its index.
module rr_arbiter
  import cordic_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx
);

  logic          found;
  logic [IW-1:0] pos;

  // First requester found when walking upward from last_grant+1
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = IW'((int'(last_grant) + k) % N_REQ);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one ap_ctrl_hs CORDIC core among N_REQ requesters.
// One transaction in flight; round-robin grant; timeout guard.
module cordic_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DW     = DW_DEF,
  parameter int TO_CYC = 1024
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  cordic_scheduler_if.slave   bus,
  output logic                core_ap_start,
  input  logic                core_ap_ready,
  input  logic                core_ap_done,
  input  logic                core_ap_idle,
  output logic [DW-1:0]       core_theta,
  input  logic [DW-1:0]       core_cos,
  input  logic [DW-1:0]       core_sin
);

  localparam int IW = id_w(N_REQ);
  localparam int CW = id_w(TO_CYC);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  state_e        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] id_q, id_d;
  logic [DW-1:0] theta_q, theta_d;
  logic [DW-1:0] cos_q, cos_d;
  logic [DW-1:0] sin_q, sin_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;
  logic          rvalid_q, rvalid_d;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic [DW-1:0]    theta_sel;
  logic             arb_go;
  logic             to_hit;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .grant      (gnt),
    .idx        (gnt_idx)
  );

  // Arbitration only once the synchronized reset release has landed
  assign arb_go = (state_q == ARB) && sync_q[1] &&
                  core_ap_idle && (|bus.req_valid);
  assign to_hit = (cnt_q == TO_LAST);

  assign bus.req_ready = arb_go ? gnt : '0;
  assign bus.rsp_valid = rvalid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_cos   = cos_q;
  assign bus.rsp_sin   = sin_q;
  assign bus.rsp_err   = err_q;
  assign core_ap_start = start_q;
  assign core_theta    = theta_q;

  // Pick the granted requester's angle
  always_comb begin
    theta_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IW'(i)) theta_sel = bus.req_theta[i*DW +: DW];
    end
  end

  // Next-state and datapath for the four-state transaction FSM
  always_comb begin
    sync_d   = {sync_q[0], 1'b1};
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    theta_d  = theta_q;
    cos_d    = cos_q;
    sin_d    = sin_q;
    err_d    = err_q;
    start_d  = start_q;
    rvalid_d = rvalid_q;
    cnt_d    = to_hit ? cnt_q : cnt_q + 1'b1;
    unique case (state_q)
      ARB: begin
        cnt_d = '0;
        if (arb_go) begin
          state_d = START;
          start_d = 1'b1;
          id_d    = gnt_idx;
          theta_d = theta_sel;
        end
      end
      START: begin
        if (core_ap_ready && core_ap_done) begin
          state_d  = RESP;
          start_d  = 1'b0;
          rvalid_d = 1'b1;
          cos_d    = core_cos;
          sin_d    = core_sin;
          err_d    = 1'b0;
        end else if (to_hit) begin
          state_d  = RESP;
          start_d  = 1'b0;
          rvalid_d = 1'b1;
          cos_d    = '0;
          sin_d    = '0;
          err_d    = 1'b1;
        end else if (core_ap_ready) begin
          state_d = WAIT;
          start_d = 1'b0;
        end
      end
      WAIT: begin
        if (core_ap_done) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          cos_d    = core_cos;
          sin_d    = core_sin;
          err_d    = 1'b0;
        end else if (to_hit) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          cos_d    = '0;
          sin_d    = '0;
          err_d    = 1'b1;
        end
      end
      RESP: begin
        cnt_d = cnt_q;
        if (bus.rsp_ready) begin
          state_d  = ARB;
          rvalid_d = 1'b0;
          last_d   = id_q;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // State registers; reset asserts immediately, release goes via sync_q
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= ARB;
      sync_q   <= '0;
      last_q   <= LAST_RST;
      id_q     <= '0;
      theta_q  <= '0;
      cos_q    <= '0;
      sin_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      last_q   <= last_d;
      id_q     <= id_d;
      theta_q  <= theta_d;
      cos_q    <= cos_d;
      sin_q    <= sin_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: doc/cordic_scheduler.md
CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters, legal range 2..16.
REQ-002 The block SHALL have parameter DW, default 16, giving the angle and result width in bits (two's complement).
REQ-003 The block SHALL have parameter TO_CYC, default 1024, giving the core timeout in cycles.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 ap_clk  in  1  sole clock, rising edge.
REQ-006 ap_rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  N_REQ  per-requester request strobe.
REQ-008 req_ready  out  N_REQ  per-requester accept, at most one bit high.
REQ-009 req_theta  in  N_REQ*DW  packed angles, requester i at bits [i*DW +: DW].
REQ-010 rsp_valid  out  1  result available.
REQ-011 rsp_ready  in  1  result consumed.
REQ-012 rsp_id  out  clog2(N_REQ)  index of the requester owning the result.
REQ-013 rsp_cos, rsp_sin  out  DW each  result data.
REQ-014 rsp_err  out  1  timeout flag for this result.
REQ-015 core_ap_start  out  1  ap_ctrl_hs start to the CORDIC core.
REQ-016 core_ap_ready, core_ap_done, core_ap_idle  in  1 each  ap_ctrl_hs status from the core.
REQ-017 core_theta  out  DW  angle operand to the core.
REQ-018 core_cos, core_sin  in  DW each  core results, valid while core_ap_done=1.

Function
REQ-019 The FSM SHALL have exactly four states, ARB, START, WAIT and RESP, with one transaction in flight at a time.
REQ-020 ARB: when core_ap_idle=1 and any req_valid is high, the block SHALL grant round-robin, searching from last_grant+1 modulo N_REQ.
REQ-021 ARB grant: the block SHALL assert req_ready for the granted requester combinationally in the same cycle, latch its theta and id, and go to START; req_ready SHALL be 0 in every other state.
REQ-022 START: core_ap_start SHALL be 1, with core_theta driven from the latch, starting the cycle after acceptance and held until core_ap_ready is sampled 1, then the FSM goes to WAIT.
REQ-023 If core_ap_done=1 and core_ap_ready=1 are sampled in the same cycle in START, the block SHALL capture the results and go directly to RESP.
REQ-024 WAIT: on core_ap_done=1 the block SHALL capture core_cos and core_sin, set rsp_err=0 and go to RESP.
REQ-025 Timeout: a counter SHALL clear on entry to START; if it reaches TO_CYC-1 without core_ap_done, the FSM SHALL go to RESP with rsp_err=1 and cos=sin=0.
REQ-026 The timeout counter SHALL saturate and never wrap.
REQ-027 RESP: rsp_valid, rsp_id, rsp_cos, rsp_sin and rsp_err SHALL be asserted and held stable until rsp_ready=1; on that cycle last_grant SHALL take rsp_id and the FSM SHALL go to ARB.
REQ-028 Latency: rsp_valid SHALL rise exactly one cycle after the cycle in which core_ap_done is sampled.
REQ-029 A new grant SHALL occur no earlier than the cycle after the rsp handshake.
REQ-030 Wrap-around: after a grant to requester N_REQ-1, the search SHALL start at requester 0.
REQ-031 If only one requester is active, it SHALL be granted on every transaction.
REQ-032 core_ap_done seen in ARB or RESP SHALL be ignored.
REQ-033 Withdrawal of req_valid before acceptance SHALL be legal and leave no state behind.

Reset
REQ-034 While ap_rst_n=0, the block SHALL drive all outputs to 0, set the state to ARB, set last_grant=N_REQ-1 (requester 0 first) and clear the timeout counter.
REQ-035 On reset assertion mid-transaction, core_ap_start SHALL drop immediately and the in-flight result SHALL be discarded; no rsp_valid SHALL follow.
REQ-036 Reset release SHALL be synchronized to ap_clk, so the first grant can occur no earlier than the second rising edge after release.

Structure
REQ-037 Package cordic_sched_pkg SHALL hold the state enum, the DW default and an id-width function.
REQ-038 Sub-module rr_arbiter (N_REQ; inputs req, last_grant; outputs one-hot grant and index) SHALL implement the round-robin search.

Verification
REQ-039 The bench SHALL cover: req_valid=4'b0100, theta=0x2000, core done 5 cycles after ready -> req_ready[2] for one cycle, core_ap_start the next cycle, rsp_id=2, rsp_err=0, rsp_valid 1 cycle after done.
REQ-040 The bench SHALL cover: req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0,1.
REQ-041 The bench SHALL cover: core_ap_done never asserted, TO_CYC=16 -> RESP 16 cycles after START entry, rsp_err=1, cos=sin=0.
REQ-042 The bench SHALL cover: rsp_ready held low 10 cycles -> rsp data stable, no req_ready asserted, core_ap_start=0.
REQ-043 The bench SHALL cover: core_ap_ready and core_ap_done both 1 on the first START cycle -> RESP the next cycle with the captured values.
REQ-044 The bench SHALL cover: ap_rst_n pulsed low during WAIT -> all outputs 0 immediately, no rsp_valid afterwards, the next grant goes to requester 0.
